// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared cache geometry and data-width constants for the fetcher
package fetcher_pkg;

   localparam int DATA_W      = 32;
   localparam int ICACHE_SIZE = 64;
   localparam int INDEX_LSB   = 2;
   localparam int INDEX_MSB   = 7;
   localparam int TAG_LSB     = 8;
   localparam int TAG_MSB     = 31;
   localparam int INDEX_W     = INDEX_MSB - INDEX_LSB + 1;
   localparam int TAG_W       = TAG_MSB - TAG_LSB + 1;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   function automatic logic [INDEX_W-1:0] pc_index(input logic [DATA_W-1:0] pc);
      return pc[INDEX_MSB:INDEX_LSB];
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input logic [DATA_W-1:0] pc);
      return pc[TAG_MSB:TAG_LSB];
   endfunction

endpackage

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped tag/data/valid array, combinational lookup, single write port
module fetcher_icache
   import fetcher_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [DATA_W-1:0]  wr_data
);

   logic [ICACHE_SIZE-1:0] valid;
   logic [TAG_W-1:0]       tags  [ICACHE_SIZE];
   logic [DATA_W-1:0]      words [ICACHE_SIZE];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         words[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = words[rd_index];

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch FSM in front of a 64-word direct-mapped I-cache
module fetcher
   import fetcher_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [DATA_W-1:0] in_next_pc,
   output logic              out_pc_ena,
   output logic [DATA_W-1:0] out_last_pc,
   output logic [DATA_W-1:0] out_last_inst,
   output logic              out_inst_valid,
   input  logic              in_decode_ready,
   output logic              out_mem_req,
   output logic [DATA_W-1:0] out_mem_addr,
   input  logic              in_mem_ack,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic              in_clear
);

   typedef enum logic [2:0] {WAIT_PC, LOOKUP, MISS, HOLD, DRAIN} state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] fetch_pc, last_pc, last_inst;
   logic              line_valid, hit;
   logic [TAG_W-1:0]  line_tag;
   logic [DATA_W-1:0] line_data;
   logic              load_pc, latch_last, deliver, pc_ena, mem_req, cache_wr;

   fetcher_icache icache (
      .clk      (clk),
      .rst      (rst),
      .rd_index (pc_index(fetch_pc)),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (cache_wr && ena && !rst),
      .wr_index (pc_index(fetch_pc)),
      .wr_tag   (pc_tag(fetch_pc)),
      .wr_data  (in_mem_data)
   );

   assign hit = line_valid && (line_tag == pc_tag(fetch_pc));

   always_comb begin
      state_next = state;
      load_pc    = 1'b0;
      latch_last = 1'b0;
      deliver    = 1'b0;
      pc_ena     = 1'b0;
      mem_req    = 1'b0;
      cache_wr   = 1'b0;
      case (state)
         WAIT_PC: begin
            // A flush here means the PC register changes on this edge, so skip the stale load.
            if (in_clear) begin
               pc_ena = 1'b1;
            end else begin
               load_pc    = 1'b1;
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (in_clear) begin
               pc_ena     = 1'b1;
               state_next = WAIT_PC;
            end else if (hit) begin
               latch_last = 1'b1;
               if (in_decode_ready) begin
                  deliver    = 1'b1;
                  pc_ena     = 1'b1;
                  state_next = WAIT_PC;
               end else begin
                  state_next = HOLD;
               end
            end else begin
               mem_req    = 1'b1;
               state_next = MISS;
            end
         end
         HOLD: begin
            if (in_clear) begin
               pc_ena     = 1'b1;
               state_next = WAIT_PC;
            end else if (in_decode_ready) begin
               deliver    = 1'b1;
               pc_ena     = 1'b1;
               state_next = WAIT_PC;
            end
         end
         MISS: begin
            mem_req  = 1'b1;
            cache_wr = in_mem_ack;
            if (in_clear) begin
               pc_ena     = 1'b1;
               state_next = in_mem_ack ? WAIT_PC : DRAIN;
            end else if (in_mem_ack) begin
               state_next = LOOKUP;
            end
         end
         DRAIN: begin
            // The outstanding read still targets fetch_pc, so its data is worth keeping.
            mem_req  = 1'b1;
            cache_wr = in_mem_ack;
            pc_ena   = in_clear;
            if (in_mem_ack) begin
               state_next = WAIT_PC;
            end
         end
         default: state_next = LOOKUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOOKUP;
         fetch_pc  <= ZERO_WORD;
         last_pc   <= ZERO_WORD;
         last_inst <= ZERO_WORD;
      end else if (ena) begin
         state <= state_next;
         if (load_pc) begin
            fetch_pc <= in_next_pc;
         end
         if (latch_last) begin
            last_pc   <= fetch_pc;
            last_inst <= line_data;
         end
      end
   end

   // Strobes are suppressed while disabled; a request already in flight stays visible.
   assign out_inst_valid = deliver && ena && !rst;
   assign out_pc_ena     = pc_ena && ena && !rst;
   assign out_mem_req    = mem_req && !rst && (ena || state != LOOKUP);
   assign out_mem_addr   = rst ? ZERO_WORD : {fetch_pc[DATA_W-1:2], 2'b00};
   assign out_last_pc    = rst ? ZERO_WORD : ((state == LOOKUP && hit) ? fetch_pc : last_pc);
   assign out_last_inst  = rst ? ZERO_WORD : ((state == LOOKUP && hit) ? line_data : last_inst);

endmodule
